// File: rtl/synth_top.sv
// SPI-programmed wavetable synth: saw/square/triangle/silence oscillator with volume,
// streamed to an I2S DAC (left-justified, same sample in both slots).
module synth_top #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned BCLK_DIV     = 16
) (
  input  logic       MASTER_CLK,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] gpio,
  output logic       dac_sys_clk,
  output logic       dac_bit_clk,
  output logic       dac_lr_clk,
  output logic       dac_data
);

  localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned PosW = $clog2(2 * SAMPLE_WIDTH);
  localparam logic [PosW-1:0] SlotLen = PosW'(SAMPLE_WIDTH);
  localparam logic [PosW-1:0] LastPos = PosW'(2 * SAMPLE_WIDTH - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
  localparam logic [31:0] FreqReset = 32'd29026936;

  // SPI input synchronizers; sck keeps a third stage for edge detection
  logic [2:0] sck_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  always_ff @(posedge MASTER_CLK) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  logic        sck_rise;
  logic [38:0] spi_shift_q;
  logic [5:0]  spi_cnt_q;
  logic [39:0] spi_word;
  logic [31:0] freq_q;
  logic [1:0]  shape_q;
  logic [7:0]  volume_q;
  logic        wr_toggle_q;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign spi_word = {spi_shift_q, mosi_sync_q[1]};

  always_ff @(posedge MASTER_CLK) begin
    if (reset) begin
      spi_shift_q <= '0;
      spi_cnt_q   <= '0;
      freq_q      <= FreqReset;
      shape_q     <= 2'd0;
      volume_q    <= 8'd255;
      wr_toggle_q <= 1'b0;
    end else if (cs_sync_q[1]) begin
      spi_cnt_q <= '0;
    end else if (sck_rise) begin
      spi_shift_q <= spi_word[38:0];
      if (spi_cnt_q == 6'd39) begin
        spi_cnt_q <= '0;
        case (spi_word[39:32])
          8'h00:   freq_q   <= spi_word[31:0];
          8'h01:   shape_q  <= spi_word[1:0];
          8'h02:   volume_q <= spi_word[7:0];
          default: ;
        endcase
        if (spi_word[39:32] <= 8'h02) wr_toggle_q <= ~wr_toggle_q;
      end else begin
        spi_cnt_q <= spi_cnt_q + 6'd1;
      end
    end
  end

  assign spi_miso = 1'b0;
  assign gpio     = {5'b0, shape_q, wr_toggle_q};

  // Oscillator: waveform derived from the phase accumulator, then volume scaled
  logic        [31:0]             phase_q;
  logic        [23:0]             w;
  logic        [22:0]             tri_t;
  logic signed [23:0]             wave;
  logic signed [32:0]             prod;
  logic signed [32:0]             scaled;
  logic        [SAMPLE_WIDTH-1:0] sample_next;

  assign w     = phase_q[31:8];
  assign tri_t = phase_q[31] ? ~w[22:0] : w[22:0];

  always_comb begin
    wave = '0;
    case (shape_q)
      2'd0:    wave = {~w[23], w[22:0]};
      2'd1:    wave = phase_q[31] ? 24'sh800001 : 24'sh7fffff;
      2'd2:    wave = {~tri_t[22], tri_t[21:0], 1'b0};
      default: wave = '0;
    endcase
  end

  assign prod        = wave * $signed({1'b0, volume_q});
  assign scaled      = prod >>> 8;
  assign sample_next = SAMPLE_WIDTH'(scaled);

  // I2S timing: frames start on a bit-clock falling edge, the first one right after reset
  logic [1:0]              sys_div_q;
  logic [DivW-1:0]         bclk_cnt_q;
  logic                    bclk_q;
  logic                    bclk_tick;
  logic                    bclk_fall;
  logic                    started_q;
  logic [PosW-1:0]         pos_q;
  logic [PosW-1:0]         pos_next;
  logic                    lr_q;
  logic                    data_q;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic [SAMPLE_WIDTH-1:0] shift_q;

  assign bclk_tick = (bclk_cnt_q == DivLast);
  assign bclk_fall = bclk_tick & bclk_q;
  assign pos_next  = (!started_q || pos_q == LastPos) ? '0 : pos_q + PosW'(1);

  always_ff @(posedge MASTER_CLK) begin
    if (reset) begin
      sys_div_q  <= '0;
      bclk_cnt_q <= '0;
      bclk_q     <= 1'b0;
      started_q  <= 1'b0;
      pos_q      <= '0;
      lr_q       <= 1'b0;
      data_q     <= 1'b0;
      sample_q   <= '0;
      shift_q    <= '0;
      phase_q    <= '0;
    end else begin
      sys_div_q <= sys_div_q + 2'd1;
      if (bclk_tick) begin
        bclk_cnt_q <= '0;
        bclk_q     <= ~bclk_q;
      end else begin
        bclk_cnt_q <= bclk_cnt_q + DivW'(1);
      end
      if (bclk_fall) begin
        started_q <= 1'b1;
        pos_q     <= pos_next;
        if (pos_next == '0) begin
          sample_q <= sample_next;
          shift_q  <= sample_next << 1;
          data_q   <= sample_next[SAMPLE_WIDTH-1];
          lr_q     <= 1'b1;
          phase_q  <= phase_q + freq_q;
        end else if (pos_next == SlotLen) begin
          shift_q <= sample_q << 1;
          data_q  <= sample_q[SAMPLE_WIDTH-1];
          lr_q    <= 1'b0;
        end else begin
          shift_q <= shift_q << 1;
          data_q  <= shift_q[SAMPLE_WIDTH-1];
        end
      end
    end
  end

  assign dac_sys_clk = sys_div_q[1];
  assign dac_bit_clk = bclk_q;
  assign dac_lr_clk  = lr_q;
  assign dac_data    = data_q;

endmodule

// File: tb/tb_synth_top.sv
// Self-checking bench for synth_top: clock timing, SPI register writes and decoded I2S
// samples compared against an arithmetic oscillator model.
module tb_synth_top;

  localparam int SW = 24;
  localparam int BD = 16;

  logic       MASTER_CLK = 1'b0;
  logic       reset      = 1'b1;
  logic       spi_clk    = 1'b0;
  logic       spi_cs     = 1'b1;
  logic       spi_mosi   = 1'b0;
  logic       spi_miso;
  logic [7:0] gpio;
  logic       dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data;

  synth_top #(.SAMPLE_WIDTH(SW), .BCLK_DIV(BD)) dut (
    .MASTER_CLK (MASTER_CLK),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .gpio       (gpio),
    .dac_sys_clk(dac_sys_clk),
    .dac_bit_clk(dac_bit_clk),
    .dac_lr_clk (dac_lr_clk),
    .dac_data   (dac_data)
  );

  always #5 MASTER_CLK = ~MASTER_CLK;

  int cyc = 0;
  always @(posedge MASTER_CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int t_rel = 0;

  // Reference model state
  logic [31:0] m_freq, m_phase;
  int          m_shape, m_vol;
  logic        m_tog;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint model_sample(input logic [31:0] ph, input int shape, input int vol);
    longint w, wave, t;
    w    = longint'(ph >> 8);
    wave = 0;
    case (shape)
      0: wave = w - 8388608;
      1: wave = (ph < 32'h8000_0000) ? 8388607 : -8388607;
      2: begin
        t    = ph[31] ? 8388607 - (w % 8388608) : (w % 8388608);
        wave = 2 * t - 8388608;
      end
      default: wave = 0;
    endcase
    return (wave * longint'(vol)) >>> 8;
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return dac_sys_clk;
      1:       return dac_bit_clk;
      default: return dac_lr_clk;
    endcase
  endfunction

  // Waits for sig(which) to reach lvl from the other level; t = cycle count, -1 on timeout
  task automatic wait_edge(input int which, input logic lvl, input int budget, output int t);
    logic prev, cur;
    t    = -1;
    prev = sig(which);
    for (int n = 0; n < budget; n++) begin
      @(negedge MASTER_CLK);
      cur = sig(which);
      if (cur === lvl && prev !== lvl) begin
        t = cyc;
        break;
      end
      prev = cur;
    end
    if (t < 0) begin
      total++;
      bad++;
      $error("FAIL edge_timeout sig=%0d: observed none expected edge within %0d", which, budget);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge MASTER_CLK);
    reset = 1'b1;
    repeat (n) @(negedge MASTER_CLK);
    check("reset_outputs", {gpio, dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data, spi_miso}, 0);
    reset   = 1'b0;
    t_rel   = cyc;
    m_freq  = 32'd29026936;
    m_phase = '0;
    m_shape = 0;
    m_vol   = 255;
    m_tog   = 1'b0;
  endtask

  task automatic spi_bits(input logic [39:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = word[39-i];
      repeat (8) @(negedge MASTER_CLK);
      spi_clk = 1'b1;
      repeat (8) @(negedge MASTER_CLK);
      spi_clk = 1'b0;
    end
  endtask

  task automatic check_gpio(input string tag);
    check({tag, "_toggle"}, gpio[0], m_tog);
    check({tag, "_shape"}, gpio[2:1], m_shape[1:0]);
    check({tag, "_upper"}, gpio[7:3], 0);
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data);
    case (addr)
      8'h00: m_freq = data;
      8'h01: m_shape = int'(data[1:0]);
      8'h02: m_vol = int'(data[7:0]);
      default: ;
    endcase
    if (addr <= 8'h02) m_tog = ~m_tog;
  endtask

  task automatic spi_write(input logic [7:0] addr, input logic [31:0] data);
    spi_cs = 1'b0;
    repeat (8) @(negedge MASTER_CLK);
    spi_bits({addr, data}, 40);
    repeat (8) @(negedge MASTER_CLK);
    spi_cs = 1'b1;
    repeat (8) @(negedge MASTER_CLK);
    model_write(addr, data);
    check_gpio("write");
  endtask

  task automatic spi_abort(input logic [7:0] addr, input logic [31:0] data);
    spi_cs = 1'b0;
    repeat (8) @(negedge MASTER_CLK);
    spi_bits({addr, data}, 20);
    repeat (8) @(negedge MASTER_CLK);
    spi_cs = 1'b1;
    repeat (8) @(negedge MASTER_CLK);
    check_gpio("abort");
  endtask

  // Captures one I2S frame (sampled on bit-clock rises) and checks both slots
  task automatic capture_frame(output longint left);
    int          t;
    logic [47:0] bits, lrs;
    longint      exp;
    wait_edge(2, 1'b1, 2000, t);
    exp     = model_sample(m_phase, m_shape, m_vol);
    m_phase = m_phase + m_freq;
    for (int i = 0; i < 48; i++) begin
      wait_edge(1, 1'b1, 100, t);
      bits[47-i] = dac_data;
      lrs[47-i]  = dac_lr_clk;
    end
    left = longint'($signed(bits[47:24]));
    check("left_sample", {{40{bits[47]}}, bits[47:24]}, exp);
    check("right_sample", {{40{bits[23]}}, bits[23:0]}, exp);
    check("lr_pattern", lrs, 48'hffffff_000000);
  endtask

  task automatic frame_action(input int f);
    int a;
    case (f)
      1:  spi_write(8'h01, 32'd1);
      3:  spi_abort(8'h02, 32'd0);
      4:  spi_write(8'h02, 32'd128);
      5:  spi_write(8'h07, $urandom);
      6:  spi_write(8'h00, $urandom);
      7:  spi_write(8'h01, 32'd2);
      8, 9, 10, 11, 12, 13: begin
        a = $urandom_range(0, 4);
        if (a == 4) spi_abort(8'($urandom_range(0, 2)), $urandom);
        else spi_write(8'(a), $urandom);
      end
      14: spi_write(8'h02, 32'd0);
      default: ;
    endcase
  endtask

  initial begin
    int     t0, t1, t2;
    longint left, prev_left;

    // Clock divider timing
    do_reset(5);
    wait_edge(2, 1'b1, 4000, t0);
    check("first_lr_rise_delay", t0 - t_rel, 2 * BD);
    check("first_lr_rise_bclk_low", dac_bit_clk, 0);
    wait_edge(0, 1'b1, 20, t0);
    wait_edge(0, 1'b1, 20, t1);
    check("sys_clk_period", t1 - t0, 4);
    wait_edge(1, 1'b1, 100, t0);
    wait_edge(1, 1'b1, 100, t1);
    check("bit_clk_period", t1 - t0, 2 * BD);
    wait_edge(2, 1'b1, 4000, t0);
    wait_edge(2, 1'b0, 4000, t1);
    wait_edge(2, 1'b1, 4000, t2);
    check("lr_high_half", t1 - t0, 768);
    check("lr_low_half", t2 - t1, 768);
    check("lr_period", t2 - t0, 1536);

    // Sample stream with directed and random register writes
    do_reset(5);
    prev_left = 0;
    for (int f = 0; f < 17; f++) begin
      fork
        capture_frame(left);
        begin
          repeat (20) @(negedge MASTER_CLK);
          frame_action(f);
        end
      join
      if (f == 0) check("default_first_saw", left, -8355840);
      if (f == 1) check("default_saw_step", left - prev_left, 112943);
      if (f == 2) check("square_first", left, 8355839);
      if (f == 15) check("volume_zero", left, 0);
      prev_left = left;
    end

    // Reset in the middle of an SPI frame
    spi_cs = 1'b0;
    repeat (8) @(negedge MASTER_CLK);
    spi_bits({8'h02, 32'h0000_00a5}, 30);
    do_reset(5);
    fork
      capture_frame(left);
      begin
        repeat (20) @(negedge MASTER_CLK);
        spi_bits({8'h01, 32'd1}, 40);
        repeat (8) @(negedge MASTER_CLK);
        spi_cs = 1'b1;
        repeat (8) @(negedge MASTER_CLK);
        model_write(8'h01, 32'd1);
        check_gpio("post_reset_write");
      end
    join
    check("post_reset_default_saw", left, -8355840);
    capture_frame(left);
    check("post_reset_square", left, 8355839);
    capture_frame(left);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
